// File: rtl/pipe_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_if
// Handshake bundle for one pipe_stage instance: the upstream side (in_*) and
// the downstream side (out_*) of the latch.
//   in_valid / in_ready   : upstream valid/ready pair
//   in_ir / in_data       : incoming instruction word and LANES payload words
//   out_valid / out_ready : downstream valid/ready pair
//   out_ir / out_data     : held instruction word and payload (bubble when empty)
// Modports:
//   master : the environment around the stage (drives in_*, out_ready)
//   slave  : the stage itself (drives in_ready, out_*)
// -----------------------------------------------------------------------------
interface pipe_stage_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 3
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_ir;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_ir;
   logic [LANES*WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_ir, in_data, out_ready,
      input  in_ready, out_valid, out_ir, out_data
   );

   modport slave (
      input  in_valid, in_ir, in_data, out_ready,
      output in_ready, out_valid, out_ir, out_data
   );
endinterface

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// Parametrised pipeline latch carrying one instruction word plus LANES payload
// words. A two-entry (main + skid) buffer keeps in_ready purely registered,
// flush squashes the stage to a bubble, and a saturating counter records
// back-pressure cycles. All state updates on the falling edge of clock.
// Ports:
//   clock       : single clock, state changes on the falling edge
//   reset       : synchronous active-high; bubble + clears stall_count
//   flush       : synchronous squash to bubble; drops a coincident accept
//   bus         : pipe_stage_if.slave handshake bundle (in_* / out_*)
//   stall_count : saturating count of edges with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_stage #(
   parameter int               WIDTH     = 32,
   parameter int               LANES     = 3,
   parameter logic [WIDTH-1:0] NOP_IR    = {WIDTH{1'b0}},
   parameter int               CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   pipe_stage_if.slave          bus,
   output logic [CNT_WIDTH-1:0] stall_count
);

   localparam int                   DW        = LANES * WIDTH;
   localparam logic [DW-1:0]        ZERO_DATA = {DW{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [WIDTH-1:0]       main_ir_r;
   logic [WIDTH-1:0]       main_ir_nxt_s;
   logic [DW-1:0]          main_data_r;
   logic [DW-1:0]          main_data_nxt_s;
   logic [WIDTH-1:0]       skid_ir_r;
   logic [WIDTH-1:0]       skid_ir_nxt_s;
   logic [DW-1:0]          skid_data_r;
   logic [DW-1:0]          skid_data_nxt_s;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic [CNT_WIDTH-1:0]   stall_cnt_r;
   logic                   accept_s;
   logic                   drain_s;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_WIDTH'(1'b1);
      end
   endfunction

   assign accept_s = bus.in_valid & in_ready_r;
   assign drain_s  = out_valid_r & bus.out_ready;

   // Every output comes straight from a flop; nothing from in_* reaches out_*.
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_ir    = main_ir_r;
   assign bus.out_data  = main_data_r;
   assign stall_count   = stall_cnt_r;

   // Next-state and holding-register selection; flush squashes to a bubble.
   always_comb begin
      state_nxt_s     = state_r;
      main_ir_nxt_s   = main_ir_r;
      main_data_nxt_s = main_data_r;
      skid_ir_nxt_s   = skid_ir_r;
      skid_data_nxt_s = skid_data_r;
      if (flush) begin
         // A coincident accept is dropped; a coincident drain has already
         // been taken downstream, so emptying does not duplicate it.
         state_nxt_s     = ST_EMPTY;
         main_ir_nxt_s   = NOP_IR;
         main_data_nxt_s = ZERO_DATA;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nxt_s     = ST_ONE;
                  main_ir_nxt_s   = bus.in_ir;
                  main_data_nxt_s = bus.in_data;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && drain_s) begin
                  main_ir_nxt_s   = bus.in_ir;
                  main_data_nxt_s = bus.in_data;
               end else if (accept_s) begin
                  // Younger entry parks in the skid while main is still held.
                  state_nxt_s     = ST_FULL;
                  skid_ir_nxt_s   = bus.in_ir;
                  skid_data_nxt_s = bus.in_data;
               end else if (drain_s) begin
                  state_nxt_s     = ST_EMPTY;
                  main_ir_nxt_s   = NOP_IR;
                  main_data_nxt_s = ZERO_DATA;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a drain can move the stage.
               if (drain_s) begin
                  state_nxt_s     = ST_ONE;
                  main_ir_nxt_s   = skid_ir_r;
                  main_data_nxt_s = skid_data_r;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            default: begin
               state_nxt_s     = ST_EMPTY;
               main_ir_nxt_s   = NOP_IR;
               main_data_nxt_s = ZERO_DATA;
            end
         endcase
      end
   end

   // State, holding registers and registered handshake flags.
   always_ff @(negedge clock) begin
      if (reset) begin
         state_r     <= ST_EMPTY;
         main_ir_r   <= NOP_IR;
         main_data_r <= ZERO_DATA;
         skid_ir_r   <= NOP_IR;
         skid_data_r <= ZERO_DATA;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         main_ir_r   <= main_ir_nxt_s;
         main_data_r <= main_data_nxt_s;
         skid_ir_r   <= skid_ir_nxt_s;
         skid_data_r <= skid_data_nxt_s;
         // Flags are precomputed from the next state so they are plain flops.
         in_ready_r  <= (state_nxt_s != ST_FULL);
         out_valid_r <= (state_nxt_s != ST_EMPTY);
      end
   end

   // Back-pressure counter; flush deliberately leaves it alone.
   always_ff @(negedge clock) begin
      if (reset) begin
         stall_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (out_valid_r && !bus.out_ready) begin
         stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
// Scoreboard bench for pipe_stage: accepted entries are pushed to a queue and
// popped when the downstream handshake completes; each scenario task checks
// the outputs against the queue head and against fixed expected sequences.
// A second instance with a 4-bit counter exercises stall saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage;
   localparam int           W   = 32;
   localparam int           L   = 3;
   localparam int           DW  = W * L;
   localparam logic [W-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [W-1:0]  ir;
      logic [DW-1:0] data;
   } ent_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        reset2;
   logic        flush2;
   logic [15:0] stall_count;
   logic [3:0]  stall2;

   int          vectors     = 0;
   int          miscompares = 0;
   ent_t        sb[$];
   logic [W-1:0] seen[$];
   int unsigned stall_exp = 0;

   pipe_stage_if #(.WIDTH(W), .LANES(L)) bus ();
   pipe_stage_if #(.WIDTH(W), .LANES(L)) bus2 ();

   pipe_stage #(.WIDTH(W), .LANES(L), .NOP_IR(NOP), .CNT_WIDTH(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus),
      .stall_count(stall_count)
   );

   pipe_stage #(.WIDTH(W), .LANES(L), .NOP_IR(NOP), .CNT_WIDTH(4)) dut_sat (
      .clock      (clock),
      .reset      (reset2),
      .flush      (flush2),
      .bus        (bus2),
      .stall_count(stall2)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] mk_data(input logic [W-1:0] ir);
      return {ir ^ 32'hFFFF_0000, ir << 4, ir + 32'd1};
   endfunction

   function automatic logic [W-1:0] exp_ir();
      return (sb.size() != 0) ? sb[0].ir : NOP;
   endfunction

   function automatic logic [DW-1:0] exp_data();
      return (sb.size() != 0) ? sb[0].data : {DW{1'b0}};
   endfunction

   task automatic offer(input logic v, input logic [W-1:0] ir);
      bus.in_valid = v;
      bus.in_ir    = ir;
      bus.in_data  = mk_data(ir);
   endtask

   // One clock: decide accept/drain from the model, let the DUT take its
   // falling edge, update the model, and return at the next rising edge.
   task automatic tick();
      logic acc;
      logic drn;
      ent_t e;
      acc    = bus.in_valid && (sb.size() < 2);
      drn    = (sb.size() != 0) && bus.out_ready;
      e.ir   = bus.in_ir;
      e.data = bus.in_data;
      if (drn) seen.push_back(bus.out_ir);
      @(negedge clock);
      if (reset) begin
         sb.delete();
         stall_exp = 0;
      end else begin
         if (sb.size() != 0 && !bus.out_ready && stall_exp != 32'd65535) stall_exp++;
         if (flush) begin
            sb.delete();
         end else begin
            if (drn) void'(sb.pop_front());
            if (acc) sb.push_back(e);
         end
      end
      @(posedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      offer(1'b1, 32'h0000_0099);
      repeat (2) tick();
      reset = 1'b0;
      offer(1'b0, 32'h0);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid act=%b exp=0", bus.out_valid); end
      vectors++; if (bus.out_ir !== NOP) begin miscompares++; $display("FAIL reset_out_ir act=%h exp=%h", bus.out_ir, NOP); end
      vectors++; if (bus.out_data !== {DW{1'b0}}) begin miscompares++; $display("FAIL reset_out_data act=%h exp=0", bus.out_data); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready act=%b exp=1", bus.in_ready); end
      vectors++; if (stall_count !== 16'd0) begin miscompares++; $display("FAIL reset_stall act=%0d exp=0", stall_count); end
   endtask

   task automatic test_streaming();
      logic [W-1:0] ir_v;
      logic [W-1:0] exp_seq [3];
      exp_seq = '{32'h11, 32'h22, 32'h33};
      seen.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ir_v = exp_seq[i];
         offer(1'b1, ir_v);
         tick();
         vectors++; if (bus.out_ir !== ir_v) begin miscompares++; $display("FAIL stream_ir beat%0d act=%h exp=%h", i, bus.out_ir, ir_v); end
         vectors++; if (bus.out_data !== mk_data(ir_v)) begin miscompares++; $display("FAIL stream_data beat%0d act=%h exp=%h", i, bus.out_data, mk_data(ir_v)); end
         vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_hs beat%0d valid=%b ready=%b exp=1/1", i, bus.out_valid, bus.in_ready); end
      end
      offer(1'b0, 32'h0);
      tick();
      vectors++; if (bus.out_valid !== 1'b0 || bus.out_ir !== NOP) begin miscompares++; $display("FAIL stream_tail valid=%b ir=%h exp=0/%h", bus.out_valid, bus.out_ir, NOP); end
      vectors++; if (seen.size() != 3) begin miscompares++; $display("FAIL stream_count act=%0d exp=3", seen.size()); end
      for (int i = 0; i < 3 && i < seen.size(); i++) begin
         vectors++; if (seen[i] !== exp_seq[i]) begin miscompares++; $display("FAIL stream_order idx%0d act=%h exp=%h", i, seen[i], exp_seq[i]); end
      end
      vectors++; if (stall_count !== 16'd0) begin miscompares++; $display("FAIL stream_stall act=%0d exp=0", stall_count); end
   endtask

   task automatic test_back_pressure();
      logic         take;
      logic [W-1:0] exp_seq [3];
      exp_seq = '{32'hA1, 32'hA2, 32'hA3};
      seen.delete();
      bus.out_ready = 1'b0;
      offer(1'b1, 32'hA1);
      tick();
      vectors++; if (bus.out_ir !== 32'hA1 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_one ir=%h ready=%b exp=a1/1", bus.out_ir, bus.in_ready); end
      offer(1'b1, 32'hA2);
      tick();
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready act=%b exp=0", bus.in_ready); end
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_ir !== 32'hA1) begin miscompares++; $display("FAIL bp_full_head valid=%b ir=%h exp=1/a1", bus.out_valid, bus.out_ir); end
      offer(1'b1, 32'hA3);
      tick();
      vectors++; if (bus.in_ready !== 1'b0 || bus.out_ir !== 32'hA1) begin miscompares++; $display("FAIL bp_hold ready=%b ir=%h exp=0/a1", bus.in_ready, bus.out_ir); end
      vectors++; if (stall_count !== 16'd2) begin miscompares++; $display("FAIL bp_stall act=%0d exp=2", stall_count); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8 && (seen.size() < 3 || bus.out_valid === 1'b1); c++) begin
         take = bus.in_valid && bus.in_ready;
         tick();
         if (take) offer(1'b0, 32'h0);
         vectors++; if (bus.out_valid !== (sb.size() != 0) || bus.in_ready !== (sb.size() < 2)) begin miscompares++; $display("FAIL bp_drain_hs cyc%0d valid=%b ready=%b exp=%b/%b", c, bus.out_valid, bus.in_ready, sb.size() != 0, sb.size() < 2); end
         vectors++; if (bus.out_ir !== exp_ir() || bus.out_data !== exp_data()) begin miscompares++; $display("FAIL bp_drain_head cyc%0d ir=%h exp=%h", c, bus.out_ir, exp_ir()); end
      end
      vectors++; if (seen.size() != 3) begin miscompares++; $display("FAIL bp_count act=%0d exp=3", seen.size()); end
      for (int i = 0; i < 3 && i < seen.size(); i++) begin
         vectors++; if (seen[i] !== exp_seq[i]) begin miscompares++; $display("FAIL bp_order idx%0d act=%h exp=%h", i, seen[i], exp_seq[i]); end
      end
      vectors++; if (stall_count !== 16'(stall_exp)) begin miscompares++; $display("FAIL bp_stall_model act=%0d exp=%0d", stall_count, stall_exp); end
   endtask

   task automatic test_flush();
      seen.delete();
      bus.out_ready = 1'b0;
      offer(1'b1, 32'hB1);
      tick();
      offer(1'b1, 32'hB2);
      tick();
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_pre_full ready=%b exp=0", bus.in_ready); end
      offer(1'b1, 32'hB3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      offer(1'b0, 32'h0);
      vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_hs valid=%b ready=%b exp=0/1", bus.out_valid, bus.in_ready); end
      vectors++; if (bus.out_ir !== NOP || bus.out_data !== {DW{1'b0}}) begin miscompares++; $display("FAIL flush_bubble ir=%h exp=%h", bus.out_ir, NOP); end
      vectors++; if (stall_count !== 16'd4) begin miscompares++; $display("FAIL flush_stall act=%0d exp=4", stall_count); end
      tick();
      vectors++; if (bus.out_valid !== 1'b0 || bus.out_ir !== NOP) begin miscompares++; $display("FAIL flush_b3_dropped valid=%b ir=%h exp=0/%h", bus.out_valid, bus.out_ir, NOP); end
      // Flush in ONE with a coincident accept and drain.
      bus.out_ready = 1'b1;
      offer(1'b1, 32'hC1);
      tick();
      offer(1'b1, 32'hC2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      offer(1'b0, 32'h0);
      vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_ir !== NOP) begin miscompares++; $display("FAIL flush_one valid=%b ready=%b ir=%h exp=0/1/%h", bus.out_valid, bus.in_ready, bus.out_ir, NOP); end
      vectors++; if (seen.size() != 1 || seen[0] !== 32'hC1) begin miscompares++; $display("FAIL flush_drain count=%0d exp=1 with c1", seen.size()); end
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_c2_dropped valid=%b exp=0", bus.out_valid); end
      vectors++; if (stall_count !== 16'(stall_exp)) begin miscompares++; $display("FAIL flush_stall_model act=%0d exp=%0d", stall_count, stall_exp); end
   endtask

   task automatic test_reset_flush();
      bus.out_ready = 1'b0;
      offer(1'b1, 32'hD1);
      tick();
      offer(1'b1, 32'hD2);
      tick();
      vectors++; if (stall_count !== 16'd5) begin miscompares++; $display("FAIL rf_pre_stall act=%0d exp=5", stall_count); end
      reset = 1'b1;
      flush = 1'b1;
      offer(1'b1, 32'hD3);
      tick();
      reset = 1'b0;
      flush = 1'b0;
      offer(1'b0, 32'h0);
      vectors++; if (stall_count !== 16'd0) begin miscompares++; $display("FAIL rf_stall act=%0d exp=0", stall_count); end
      vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rf_hs valid=%b ready=%b exp=0/1", bus.out_valid, bus.in_ready); end
      vectors++; if (bus.out_ir !== NOP || bus.out_data !== {DW{1'b0}}) begin miscompares++; $display("FAIL rf_bubble ir=%h exp=%h", bus.out_ir, NOP); end
      bus.out_ready = 1'b1;
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rf_after valid=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_stall_saturation();
      logic [3:0] e;
      reset2          = 1'b0;
      bus2.in_valid   = 1'b1;
      bus2.in_ir      = 32'hE1;
      bus2.in_data    = mk_data(32'hE1);
      bus2.out_ready  = 1'b0;
      @(negedge clock);
      @(posedge clock);
      bus2.in_valid = 1'b0;
      vectors++; if (bus2.out_valid !== 1'b1 || bus2.out_ir !== 32'hE1 || stall2 !== 4'd0) begin miscompares++; $display("FAIL sat_start valid=%b ir=%h cnt=%0d exp=1/e1/0", bus2.out_valid, bus2.out_ir, stall2); end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         @(posedge clock);
         e = (k >= 15) ? 4'd15 : 4'(k);
         if (k == 14 || k == 15 || k == 20) begin
            vectors++; if (stall2 !== e) begin miscompares++; $display("FAIL sat_count k%0d act=%0d exp=%0d", k, stall2, e); end
         end
      end
      vectors++; if (bus2.out_valid !== 1'b1 || bus2.out_ir !== 32'hE1) begin miscompares++; $display("FAIL sat_hold valid=%b ir=%h exp=1/e1", bus2.out_valid, bus2.out_ir); end
   endtask

   initial begin
      reset          = 1'b1;
      flush          = 1'b0;
      reset2         = 1'b1;
      flush2         = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_ir      = 32'h0;
      bus.in_data    = {DW{1'b0}};
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_ir     = 32'h0;
      bus2.in_data   = {DW{1'b0}};
      bus2.out_ready = 1'b0;
      @(posedge clock);
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_reset_flush();
      test_stall_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline latch that generalises the fixed FD/DX/XM/MW latches. It carries one instruction word plus `LANES` payload words of `WIDTH` bits, with a valid/ready handshake, a two-entry skid buffer so `in_ready` is a registered signal, flush-to-bubble, and a saturating stall-cycle counter. It sits between any two pipeline stages, and multiple instances replace the per-stage hand-written latches.

## Interface
- `WIDTH`, 32, width of the IR and of each payload lane
- `LANES`, 3, number of payload words carried alongside IR (≥1)
- `NOP_IR`, 32'h0000_0000, IR value presented whenever the stage holds a bubble
- `CNT_WIDTH`, 16, width of the stall counter
- `clock`  in  1  single clock; all state updates on the falling edge (`~clock`), same as the existing latches
- `reset`  in  1  synchronous, active-high; sampled on the falling edge
- `flush`  in  1  synchronous squash of all held contents
- `in_valid`  in  1  upstream holds a valid entry
- `in_ready`  out  1  stage can accept; driven directly from a register
- `in_ir`  in  WIDTH  incoming instruction
- `in_data`  in  LANES*WIDTH  incoming payload; lane k is bits [k*WIDTH +: WIDTH]
- `out_valid`  out  1  stage presents a valid entry
- `out_ready`  in  1  downstream accepts
- `out_ir`  out  WIDTH  held instruction, or NOP_IR when empty
- `out_data`  out  LANES*WIDTH  held payload, or zero when empty
- `stall_count`  out  CNT_WIDTH  saturating count of back-pressure cycles

## Operation
- Storage: main register (drives outputs) plus skid register, and a state register with values EMPTY, ONE and FULL.
- accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- `in_ready` = (state != FULL). `out_valid` = (state != EMPTY).
- Transitions, in priority order after reset and flush:
  - EMPTY, accept → ONE; main ← in.
  - ONE, accept & drain → ONE; main ← in.
  - ONE, accept & !drain → FULL; skid ← in.
  - ONE, drain & !accept → EMPTY; main ← {NOP_IR, 0}.
  - FULL, drain → ONE; main ← skid. No accept is possible, because `in_ready`=0.
  - No event → hold.
- Ordering is strict FIFO. The skid entry is always younger than the main entry.
- `flush`:
  - Next state EMPTY; main ← {NOP_IR, 0}; skid contents are don't-care.
  - An accept that coincides with `flush` is discarded, because upstream is being squashed too.
  - A drain in the same cycle still completes downstream. The entry is consumed, not duplicated.
- `reset`: same as flush, and also clears `stall_count` to 0. Reset overrides flush.
- `stall_count`:
  - Increments on each falling edge where `out_valid & !out_ready`.
  - Saturates at 2^CNT_WIDTH−1.
  - Cleared only by reset; unaffected by flush.
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `out_ir`=NOP_IR, `out_data`=0, `stall_count`=0.

## Timing
- Latency: an entry accepted at falling edge n appears on `out_*` after edge n when the stage was EMPTY or was draining in ONE. It appears one edge later per held entry ahead of it.
- Throughput: one entry per cycle while `out_ready`=1.
- `in_ready` responds one edge after the stage fills. The skid register absorbs the single extra beat that upstream may launch in that window.
- Outputs are purely registered, with no combinational path from `in_*` to `out_*`. `out_ready` affects only the next state.
- Flush and reset take effect at the same edge that samples them. Outputs show the bubble immediately after that edge, and `in_ready`=1.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid`=1 → `out_valid`=0, `out_ir`=NOP_IR, `out_data`=0, `in_ready`=1, `stall_count`=0.
- Streaming:
  - Stimulus: `out_ready`=1; inject IR 0x11,0x22,0x33 on consecutive cycles, with lane0 = IR+1.
  - Required: the same sequence appears one edge later, back-to-back; `stall_count` stays 0.
- Back-pressure/skid:
  - Stimulus: inject 0xA1,0xA2,0xA3 with `out_ready`=0.
  - Required: state FULL after 0xA2; `in_ready`=0; 0xA3 is held upstream.
  - Stimulus: raise `out_ready`.
  - Required: outputs 0xA1,0xA2,0xA3 in order with no loss or duplication.
- Flush while FULL:
  - Stimulus: assert `flush` with 0xB3 offered.
  - Required: next output is NOP_IR with `out_valid`=0 and `in_ready`=1; 0xB3 is not captured.
  - Required: `stall_count` keeps its value.
- Stall saturation: with CNT_WIDTH=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_count`=15.
- Simultaneous reset and flush mid-stream → reset behaviour, including `stall_count`=0.
